// File: rtl/mandelbrot_iter_pkg.sv
// Shared types and constants for the Mandelbrot escape-time engine.
package mandel_pkg;

    // Default fixed-point format: Q4.28 in a 32-bit word.
    localparam int W_DEF    = 32;
    localparam int FRAC_DEF = 28;

    // Width of re^2 + im^2: the 2W-FRAC bit squares plus one carry bit.
    localparam int MAG_W_DEF = 2 * W_DEF - FRAC_DEF + 1;

    // Escape threshold |z|^2 > 4, expressed at the magnitude width.
    localparam logic [MAG_W_DEF-1:0] ESC = MAG_W_DEF'(4) << FRAC_DEF;

    // Engine FSM: wait for a coordinate, iterate, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mandelbrot_iter_if.sv
// Request/result handshake bundle between a pixel source and the engine.
interface mandelbrot_iter_if #(
    parameter int W     = 32,
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  c_re;
    logic signed [W-1:0]  c_im;
    logic [X_W-1:0]       in_x;
    logic [Y_W-1:0]       in_y;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_W-1:0]     iteration_count;
    logic [X_W-1:0]       out_x;
    logic [Y_W-1:0]       out_y;

    // Pixel source side: issues coordinates, consumes results.
    modport master (
        output in_valid, c_re, c_im, in_x, in_y, out_ready,
        input  in_ready, out_valid, iteration_count, out_x, out_y
    );

    // Engine side.
    modport slave (
        input  in_valid, c_re, c_im, in_x, in_y, out_ready,
        output in_ready, out_valid, iteration_count, out_x, out_y
    );
endinterface

// File: rtl/mandelbrot_iter_fx_mul.sv
// Signed fixed-point multiply: full 2W-bit product, arithmetic shift by FRAC.
module fx_mul #(
    parameter int W    = 32,
    parameter int FRAC = 28
) (
    input  logic signed [W-1:0]          i_a,
    input  logic signed [W-1:0]          i_b,
    output logic signed [2*W-FRAC-1:0]   o_p
);
    // Both operands are widened before multiplying so nothing is lost; the
    // arithmetic shift floors toward minus infinity and the upper sign copies
    // are dropped by the final cast.
    assign o_p = (2*W-FRAC)'(((2*W)'(i_a) * (2*W)'(i_b)) >>> FRAC);
endmodule

// File: rtl/mandelbrot_iter.sv
// Per-pixel Mandelbrot escape-time engine: one iteration of z <- z^2 + c
// per clock, reporting the escape count together with the pixel tag.
module mandelbrot_iter
    import mandel_pkg::*;
#(
    parameter int MAX_ITER = 256,
    parameter int W        = W_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    mandelbrot_iter_if.slave  io_bus
);
    localparam int CNT_W = $clog2(MAX_ITER);
    localparam int PW    = 2 * W - FRAC;
    localparam int MAG_W = PW + 1;
    localparam logic [MAG_W-1:0] ESC_T  = MAG_W'(4) << FRAC;
    localparam logic [CNT_W-1:0] N_LAST = CNT_W'(MAX_ITER - 1);

    state_t                r_state;
    logic signed [W-1:0]   r_c_re;
    logic signed [W-1:0]   r_c_im;
    logic signed [W-1:0]   r_z_re;
    logic signed [W-1:0]   r_z_im;
    logic [CNT_W-1:0]      r_n;
    logic [CNT_W-1:0]      r_count;
    logic [X_W-1:0]        r_x;
    logic [Y_W-1:0]        r_y;

    logic signed [PW-1:0]  w_re2;
    logic signed [PW-1:0]  w_im2;
    logic signed [PW-1:0]  w_reim;
    logic [MAG_W-1:0]      w_mag;
    logic                  w_escape;
    logic signed [W-1:0]   w_zre_next;
    logic signed [W-1:0]   w_zim_next;

    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_re2  (.i_a(r_z_re), .i_b(r_z_re), .o_p(w_re2));
    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_im2  (.i_a(r_z_im), .i_b(r_z_im), .o_p(w_im2));
    fx_mul #(.W(W), .FRAC(FRAC)) u_mul_reim (.i_a(r_z_re), .i_b(r_z_im), .o_p(w_reim));

    // Squares are never negative, so the magnitude sum is kept one bit wider
    // and compared unsigned; exactly 4.0 counts as bounded.
    assign w_mag    = MAG_W'(w_re2) + MAG_W'(w_im2);
    assign w_escape = (w_mag > ESC_T);

    // Next z; bounded |z| <= 2 and |c| <= 2 keep these inside the word.
    assign w_zre_next = W'(w_re2 - w_im2 + PW'(r_c_re));
    assign w_zim_next = W'((w_reim <<< 1) + PW'(r_c_im));

    // Outputs come straight from registers so no input reaches an output
    // combinationally.
    assign io_bus.in_ready        = (r_state == IDLE);
    assign io_bus.out_valid       = (r_state == DONE);
    assign io_bus.iteration_count = r_count;
    assign io_bus.out_x           = r_x;
    assign io_bus.out_y           = r_y;

    // FSM: latch a coordinate, iterate until escape or cap, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_c_re  <= '0;
            r_c_im  <= '0;
            r_z_re  <= '0;
            r_z_im  <= '0;
            r_n     <= '0;
            r_count <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_c_re  <= io_bus.c_re;
                        r_c_im  <= io_bus.c_im;
                        r_x     <= io_bus.in_x;
                        r_y     <= io_bus.in_y;
                        r_z_re  <= '0;
                        r_z_im  <= '0;
                        r_n     <= '0;
                        r_state <= ITER;
                    end
                end
                ITER: begin
                    if (w_escape || (r_n == N_LAST)) begin
                        r_count <= r_n;
                        r_state <= DONE;
                    end else begin
                        r_z_re <= w_zre_next;
                        r_z_im <= w_zim_next;
                        r_n    <= r_n + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (io_bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mandelbrot_iter.sv
// Directed bench for the Mandelbrot escape-time engine.
module tb_mandelbrot_iter;

    typedef struct {
        logic signed [31:0] cRe;
        logic signed [31:0] cIm;
        logic [9:0]         x;
        logic [9:0]         y;
        int                 expCount;
        int                 expLat;
    } vec_t;

    localparam int WAIT_LIMIT = 600;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[8];

    mandelbrot_iter_if #(.W(32), .X_W(10), .Y_W(10), .CNT_W(8)) bus ();

    mandelbrot_iter #(
        .MAX_ITER(256), .W(32), .FRAC(28), .X_W(10), .Y_W(10)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case the design wedges somewhere unexpected.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 2 ms");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    // Presents a coordinate for exactly one accepting edge.
    task automatic applyStimulus(input logic signed [31:0] cRe, input logic signed [31:0] cIm,
                                 input logic [9:0] x, input logic [9:0] y);
        int guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.c_re     = cRe;
        bus.c_im     = cIm;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts cycles after the accepting edge until out_valid shows up.
    task automatic waitResult(output int cyc);
        cyc = 1;
        while (!bus.out_valid && cyc < WAIT_LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int cyc;
        applyStimulus(v.cRe, v.cIm, v.x, v.y);
        waitResult(cyc);
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(v.expLat));
        checkOutput({tag, "_count"}, 64'(bus.iteration_count), 64'(v.expCount));
        checkOutput({tag, "_out_x"}, 64'(bus.out_x), 64'(v.x));
        checkOutput({tag, "_out_y"}, 64'(bus.out_y), 64'(v.y));
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 64'(bus.out_valid), 64'(0));
        checkOutput({tag, "_ready_back"}, 64'(bus.in_ready), 64'(1));
    endtask

    initial begin
        int cyc;

        // Q4.28 constants: 1.0 = 0x1000_0000.
        vecs[0] = '{32'sh3000_0000, 32'sh0000_0000, 10'd5,  10'd7,  1,   3};
        vecs[1] = '{32'sh2000_0000, 32'sh0000_0000, 10'd11, 10'd12, 2,   4};
        vecs[2] = '{32'shE000_0000, 32'sh0000_0000, 10'd13, 10'd14, 255, 257};
        vecs[3] = '{32'sh0000_0000, 32'sh0000_0000, 10'd15, 10'd16, 255, 257};
        vecs[4] = '{32'shF000_0000, 32'sh0000_0000, 10'd17, 10'd18, 255, 257};
        vecs[5] = '{32'sh0000_0000, 32'sh1000_0000, 10'd19, 10'd20, 255, 257};
        vecs[6] = '{32'sh0800_0000, 32'sh0000_0000, 10'd21, 10'd22, 5,   7};
        vecs[7] = '{32'sh0000_0000, 32'sh2000_0000, 10'd23, 10'd24, 2,   4};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.c_re      = '0;
        bus.c_im      = '0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        #1;
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("rst_count", 64'(bus.iteration_count), 64'(0));
        checkOutput("rst_out_x", 64'(bus.out_x), 64'(0));
        checkOutput("rst_out_y", 64'(bus.out_y), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'(0));

        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold the result while ignored requests arrive.
        applyStimulus(32'sh3000_0000, 32'sh0000_0000, 10'd9, 10'd3);
        waitResult(cyc);
        checkOutput("bp_latency", 64'(cyc), 64'(3));
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.c_re     = 32'sh1000_0000;
            bus.in_x     = 10'd100;
            bus.in_y     = 10'd200;
            @(posedge clk); #1;
            checkOutput($sformatf("bp%0d_valid", k), 64'(bus.out_valid), 64'(1));
            checkOutput($sformatf("bp%0d_count", k), 64'(bus.iteration_count), 64'(1));
            checkOutput($sformatf("bp%0d_x", k), 64'(bus.out_x), 64'(9));
            checkOutput($sformatf("bp%0d_y", k), 64'(bus.out_y), 64'(3));
            checkOutput($sformatf("bp%0d_in_ready", k), 64'(bus.in_ready), 64'(0));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checkOutput("bp_release_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("bp_release_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk); #1;
        checkOutput("bp_still_idle", 64'(bus.in_ready), 64'(1));

        // Reset in the middle of a long iteration run.
        applyStimulus(32'sh0000_0000, 32'sh0000_0000, 10'd33, 10'd44);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("midrun_busy", 64'(bus.in_ready), 64'(0));
        checkOutput("midrun_tag_x", 64'(bus.out_x), 64'(33));
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("async_rst_ready", 64'(bus.in_ready), 64'(1));
        checkOutput("async_rst_count", 64'(bus.iteration_count), 64'(0));
        checkOutput("async_rst_x", 64'(bus.out_x), 64'(0));
        checkOutput("async_rst_y", 64'(bus.out_y), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("after_rst_no_result", 64'(bus.out_valid), 64'(0));

        runVector('{32'sh3000_0000, 32'sh0000_0000, 10'd1, 10'd1, 1, 3}, "b2b_first");
        runVector('{32'sh2000_0000, 32'sh0000_0000, 10'd2, 10'd2, 2, 4}, "b2b_second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mandelbrot_iter.md
# mandelbrot_iter

Per-pixel Mandelbrot escape-time engine. It accepts one complex coordinate c per transaction plus a pixel tag (x, y) and iterates z ← z² + c in signed fixed point until |z|² > 4 or the iteration cap is reached. It returns the iteration count with the tag. It sits directly upstream of the framebuffer / palette lookup; its count is the value the palette stage maps to RGB, with MAX_ITER-1 meaning "inside the set".

## Interface

Parameters:
- MAX_ITER, 256: iteration cap. Count range is 0..MAX_ITER-1; MAX_ITER-1 means non-escaping.
- W, 32: signed fixed-point word width for c and z.
- FRAC, 28: fractional bits (Q4.28 at defaults).
- X_W, 10: pixel x tag width.
- Y_W, 10: pixel y tag width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  coordinate request valid.
- in_ready  out  1  engine idle and able to accept.
- c_re  in  W  signed real part of c, Q(W-FRAC).FRAC.
- c_im  in  W  signed imaginary part of c.
- in_x  in  X_W  pixel x tag, passed through unchanged.
- in_y  in  Y_W  pixel y tag, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- iteration_count  out  $clog2(MAX_ITER)  escape iteration.
- out_x  out  X_W  tag of the result.
- out_y  out  Y_W  tag of the result.

## Operation

- FSM has three states: IDLE, ITER, DONE. The state type and the encoding live in the package.
- IDLE: in_ready=1. On in_valid && in_ready:
  - latch c_re, c_im, in_x, in_y;
  - set z_re=z_im=0 and n=0;
  - go to ITER.
- ITER: one iteration per cycle. From the current z:
  - re2 = (z_re·z_re)>>>FRAC, im2 = (z_im·z_im)>>>FRAC, reim = (z_re·z_im)>>>FRAC.
  - Products are full 2W-bit signed. The shift is arithmetic (floor, no rounding).
  - mag = re2 + im2, computed at 2W-FRAC+1 bits with no truncation.
  - Escape when mag > (4<<FRAC), strictly greater. mag == 4 does not escape.
  - If escape or n == MAX_ITER-1: iteration_count ← n, go to DONE.
  - Otherwise: z_re ← re2 − im2 + c_re, z_im ← (reim<<1) + c_im (truncated to W bits), n ← n+1.
- Input range: behaviour is defined for |c_re|, |c_im| ≤ 2.0. Non-escaped |z| ≤ 2, so the next z components are ≤ 6 and fit Q4.28 without wrap. Out-of-range c is outside contract.
- DONE: out_valid=1. iteration_count, out_x and out_y are held stable until out_valid && out_ready, then the FSM goes to IDLE.
- in_ready = (state==IDLE). No new request is accepted in ITER or DONE.
- in_valid while not ready is ignored. Upstream holds its data per the valid/ready rule.

## Timing

- Reset (asynchronous, active-low) applies immediately, regardless of state. Values while rst_n=0 and after release:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - iteration_count = 0, out_x = 0, out_y = 0;
  - internal z, n and latched c = 0.
- Reset mid-ITER or mid-DONE drops the transaction. No partial result is emitted.
- Latency: with the handshake in cycle 0, ITER runs cycles 1..1+count and out_valid is high from cycle 2+count. Worst case (count = MAX_ITER-1) puts out_valid in cycle MAX_ITER+1.
- Result handshake in cycle k (out_ready=1): out_valid=0 and in_ready=1 in cycle k+1. The earliest next acceptance is cycle k+1.
- Throughput: one pixel per count+3 cycles minimum. There is no overlap between pixels.
- out_ready is don't-care outside DONE. There are no combinational paths from inputs to outputs.

## Structure

- Package mandel_pkg holds:
  - the state enum {IDLE, ITER, DONE};
  - the default W and FRAC;
  - the escape threshold constant ESC = 4<<FRAC at the magnitude width.
- One sub-module, fx_mul: signed W×W multiply, 2W-bit product, arithmetic >>> FRAC, output at 2W-FRAC bits.
  - Three instances: re², im², re·im.
  - Purely combinational; registering is left to the parent.
- The top holds the FSM, the z/n registers, the escape compare, and the tag/c latches.

## Test plan

- c=3.0+0i, tag (5,7): count=1; out_valid in cycle 3 after handshake in cycle 0; out_x=5, out_y=7.
- c=2.0+0i: sequence z = 0, 2, 6; mag=4 at n=1 does not escape; count=2; out_valid in cycle 4.
- c=−2.0+0i: z oscillates at 2, mag==4 every cycle and never strictly greater; count=255; out_valid in cycle 257.
- c=0+0i and c=−1+0i: count=255. Separately, c=0+1i: the z values ±i stay bounded, count=255.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Outputs must stay constant, in_ready=0, and in_valid pulses are ignored. On release, in_ready=1 in the next cycle.
- Reset: assert rst_n=0 during ITER at n=40. Expect out_valid=0 and in_ready=1 immediately. After release, a back-to-back pair with c=3 (tag 1,1) then c=2 (tag 2,2) returns counts 1 then 2 with the correct tags.
